// File: rtl/wb_pkg.sv
// Shared defaults and types for the writeback arbiter and its port-1 FIFO.
package wb_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH    = 32;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0]    data;
    } wb_req_t;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } grant_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous count-based FIFO buffering port-1 writeback requests.
// With WB_SCOREBOARD_EN defined, storage and per-entry valid flags are exported.
module wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [DEPTH-1:0][WIDTH-1:0]  mem_o,
    output logic [DEPTH-1:0]             valid_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PW:0]                 count_q, count_d;
    logic                        do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Power-of-two depth: pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + (PW+1)'(1);
        if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

`ifdef WB_SCOREBOARD_EN
    assign mem_o = mem_q;

    always_comb begin
        valid_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_o[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of port 0 (ALU) and FIFO-buffered port 1 onto one write port.
// Define WB_SCOREBOARD_EN to build the per-register pending-write flags on busy_vec.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned P1_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        p0_valid,
    output logic                        p0_ready,
    input  logic [ADDRESS_WIDTH-1:0]    p0_rd,
    input  logic [DATA_WIDTH-1:0]       p0_data,
    input  logic                        p1_valid,
    output logic                        p1_ready,
    input  logic [ADDRESS_WIDTH-1:0]    p1_rd,
    input  logic [DATA_WIDTH-1:0]       p1_data,
    output logic                        WE3,
    output logic [ADDRESS_WIDTH-1:0]    AD3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic [2**ADDRESS_WIDTH-1:0] busy_vec
);

    localparam int unsigned REQ_W = ADDRESS_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } req_t;

    req_t                      head;
    logic                      fifo_full, fifo_empty;
    logic                      grant_p0, grant_p1;
    grant_t                    last_grant_q, last_grant_d;
    logic                      we_q, we_d;
    logic [ADDRESS_WIDTH-1:0]  ad_q, ad_d;
    logic [DATA_WIDTH-1:0]     wd_q, wd_d;

`ifdef WB_SCOREBOARD_EN
    logic [P1_DEPTH-1:0][REQ_W-1:0] fifo_mem;
    logic [P1_DEPTH-1:0]            fifo_valid;
`endif

    wb_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (P1_DEPTH)
    ) u_p1_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (p1_valid && p1_ready),
        .pop_i   (grant_p1),
        .wdata_i ({p1_rd, p1_data}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
`ifdef WB_SCOREBOARD_EN
        ,
        .mem_o   (fifo_mem),
        .valid_o (fifo_valid)
`endif
    );

    assign p1_ready = !fifo_full;
    assign p0_ready = fifo_empty || (last_grant_q == P1);

    // p0_ready already encodes the round-robin decision, so a p0 transfer is exactly a P0 grant.
    assign grant_p0 = p0_valid && p0_ready;
    assign grant_p1 = !fifo_empty && !grant_p0;

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        ad_d         = ad_q;
        wd_d         = wd_q;
        if (grant_p0) begin
            last_grant_d = P0;
            we_d         = (p0_rd != '0);
            ad_d         = p0_rd;
            wd_d         = p0_data;
        end else if (grant_p1) begin
            last_grant_d = P1;
            we_d         = (head.rd != '0);
            ad_d         = head.rd;
            wd_d         = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= P1;
            we_q         <= 1'b0;
            ad_q         <= '0;
            wd_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            ad_q         <= ad_d;
            wd_q         <= wd_d;
        end
    end

    assign WE3 = we_q;
    assign AD3 = ad_q;
    assign WD3 = wd_q;

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        busy_vec = '0;
        for (int unsigned i = 0; i < P1_DEPTH; i++) begin
            if (fifo_valid[i]) busy_vec[fifo_mem[i][REQ_W-1 -: ADDRESS_WIDTH]] = 1'b1;
        end
        if (we_q) busy_vec[ad_q] = 1'b1;
        busy_vec[0] = 1'b0;
    end
`else
    assign busy_vec = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based reference model of the arbitration rules.
// busy_vec expectations follow WB_SCOREBOARD_EN as compiled.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned AW    = DEF_ADDRESS_WIDTH;
    localparam int unsigned DW    = DEF_DATA_WIDTH;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p0_valid, p0_ready, p1_valid, p1_ready;
    logic [AW-1:0]     p0_rd, p1_rd, AD3;
    logic [DW-1:0]     p0_data, p1_data, WD3;
    logic              WE3;
    logic [2**AW-1:0]  busy_vec;

    always #5 clk = ~clk;

    wb_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .P1_DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0_valid (p0_valid),
        .p0_ready (p0_ready),
        .p0_rd    (p0_rd),
        .p0_data  (p0_data),
        .p1_valid (p1_valid),
        .p1_ready (p1_ready),
        .p1_rd    (p1_rd),
        .p1_data  (p1_data),
        .WE3      (WE3),
        .AD3      (AD3),
        .WD3      (WD3),
        .busy_vec (busy_vec)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    wb_req_t       model_q[$];
    grant_t        model_last = P1;
    bit            model_known = 1'b0;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_ad = '0;
    logic [DW-1:0] exp_wd = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2**AW-1:0] exp_busy();
        logic [2**AW-1:0] b = '0;
`ifdef WB_SCOREBOARD_EN
        foreach (model_q[i]) if (model_q[i].rd != '0) b[model_q[i].rd] = 1'b1;
        if (exp_we) b[exp_ad] = 1'b1;
`endif
        return b;
    endfunction

    // One clock cycle: drive inputs, check readiness, advance the model, check outputs.
    task automatic step(input bit rst, input bit v0, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] rd1, input logic [DW-1:0] d1);
        bit      exp_r0, exp_r1, win0;
        wb_req_t r;
        @(negedge clk);
        rst_n    = !rst;
        p0_valid = v0;
        p0_rd    = rd0;
        p0_data  = d0;
        p1_valid = v1;
        p1_rd    = rd1;
        p1_data  = d1;
        #1;
        exp_r0 = (model_q.size() == 0) || (model_last == P1);
        exp_r1 = (model_q.size() < DEPTH);
        if (model_known) begin
            check_eq("p0_ready", 64'(p0_ready), 64'(exp_r0));
            check_eq("p1_ready", 64'(p1_ready), 64'(exp_r1));
        end
        if (rst) begin
            model_q.delete();
            model_last  = P1;
            model_known = 1'b1;
            exp_we      = 1'b0;
            exp_ad      = '0;
            exp_wd      = '0;
        end else begin
            if (v0 && model_q.size() > 0) win0 = (model_last != P0);
            else                          win0 = v0;
            if (win0) begin
                exp_we     = (rd0 != '0);
                exp_ad     = rd0;
                exp_wd     = d0;
                model_last = P0;
            end else if (model_q.size() > 0) begin
                r          = model_q.pop_front();
                exp_we     = (r.rd != '0);
                exp_ad     = r.rd;
                exp_wd     = r.data;
                model_last = P1;
            end else begin
                exp_we = 1'b0;
            end
            if (v1 && exp_r1) begin
                r.rd   = rd1;
                r.data = d1;
                model_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        check_eq("WE3", 64'(WE3), 64'(exp_we));
        check_eq("AD3", 64'(AD3), 64'(exp_ad));
        check_eq("WD3", 64'(WD3), 64'(exp_wd));
        check_eq("busy_vec", 64'(busy_vec), 64'(exp_busy()));
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
        p0_rd = '0; p0_data = '0; p1_rd = '0; p1_data = '0;

        repeat (2) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

        // single p0 write, then idle
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        idle(2);

        // x0 write is granted but suppressed
        step(1'b0, 1'b1, 5'd0, 32'h1, 1'b0, '0, '0);
        idle(2);

        // contention: p0 held valid while p1 pushes three entries
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, AW'(i + 1), DW'(32'h100 + i), 1'b1, AW'(i + 8), DW'(32'h200 + i));
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, AW'(i + 1), DW'(32'h110 + i), 1'b0, '0, '0);
        idle(4);

        // fill: p1 pushes continuously while p0 contends
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 5'd3, DW'(32'h300 + i), 1'b1, 5'd12, DW'(32'h400 + i));
        idle(8);

        // pending write to x10 tracked while p0 wins first
        step(1'b0, 1'b1, 5'd4, 32'hA5A5, 1'b1, 5'd10, 32'hC0FFEE);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, AW'(i + 20), DW'(32'h500 + i), 1'b0, '0, '0);
        idle(3);

        // reset with entries still queued
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, AW'(i + 1), DW'(32'h600 + i), 1'b1, AW'(i + 16), DW'(32'h700 + i));
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(2);

        // randomized traffic with occasional resets
        repeat (2000) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 6, AW'($urandom_range(0, 31)), DW'($urandom),
                 $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom));
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
